// File: rtl/ehl_cg_ctrl_pkg.sv
// Shared types for the clock-gate controller: FSM encoding and counter sizing.
package ehl_cg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_HOLD = 2'd3
    } cg_state_t;

    localparam int STATS_W = 16;

    // Bits needed to hold a down-counter loaded with (n-1); never below one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ehl_cg_ctrl_if.sv
// Requester/gate bundle of the clock-gate controller; master = requester side, slave = controller.
interface ehl_cg_ctrl_if #(
    parameter int REQ_NUM = 4,
    parameter int IDLE_W  = 8
);
    logic [REQ_NUM-1:0] req_i;
    logic [REQ_NUM-1:0] ack_o;
    logic [IDLE_W-1:0]  idle_cycles_i;
    logic               test_en_i;
    logic               cg_en_o;
    logic               gclk_o;
    logic               busy_o;

    modport master (
        output req_i, idle_cycles_i, test_en_i,
        input  ack_o, cg_en_o, gclk_o, busy_o
    );

    modport slave (
        input  req_i, idle_cycles_i, test_en_i,
        output ack_o, cg_en_o, gclk_o, busy_o
    );
endinterface

// File: rtl/ehl_cg.sv
// Glitch-free clock gate: enable captured while clk is low, so gclk pulses are never truncated.
// TECHNOLOGY 0 = transparent-low latch, otherwise a falling-edge flop equivalent.
module ehl_cg #(
    parameter int TECHNOLOGY = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic gclk
);
    logic en_lat;

    generate
        if (TECHNOLOGY == 0) begin : g_latch
            always_latch begin
                if (!reset_n)
                    en_lat <= 1'b0;
                else if (!clk)
                    en_lat <= en;
            end
        end else begin : g_negflop
            always_ff @(negedge clk or negedge reset_n) begin
                if (!reset_n)
                    en_lat <= 1'b0;
                else
                    en_lat <= en;
            end
        end
    endgenerate

    assign gclk = clk & en_lat;

endmodule

// File: rtl/ehl_cg_ctrl.sv
// Shared gated-clock branch controller: wake delay WAKE_CYCLES before ack, programmable idle hold-off.
// Requests are levels (no backpressure); EHL_CG_CTRL_STATS_EN adds the wake_cnt_o wake-up counter.
module ehl_cg_ctrl
    import ehl_cg_ctrl_pkg::*;
#(
    parameter int TECHNOLOGY  = 0,
    parameter int REQ_NUM     = 4,
    parameter int IDLE_W      = 8,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    ehl_cg_ctrl_if.slave        cg_if
`ifdef EHL_CG_CTRL_STATS_EN
    ,
    output logic [STATS_W-1:0]  wake_cnt_o
`endif
);
    localparam int                WAKE_W    = cnt_w(WAKE_CYCLES);
    localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 1);

    cg_state_t          state;
    logic [WAKE_W-1:0]  wake_cnt;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [REQ_NUM-1:0] ack_q;
    logic               cg_en_q;
    logic               busy_q;
    logic               any_req;

    assign any_req = |cg_if.req_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_OFF;
            wake_cnt <= '0;
            idle_cnt <= '0;
            ack_q    <= '0;
            cg_en_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    ack_q <= '0;
                    if (any_req) begin
                        state    <= ST_WAKE;
                        wake_cnt <= WAKE_LOAD;
                        cg_en_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                ST_WAKE: begin
                    // Completes even if the request vanished; ON then sees no request.
                    if (wake_cnt == '0) begin
                        state <= ST_ON;
                        ack_q <= cg_if.req_i;
                    end else begin
                        wake_cnt <= wake_cnt - WAKE_W'(1);
                    end
                end
                ST_ON: begin
                    ack_q <= cg_if.req_i;
                    if (!any_req) begin
                        if (cg_if.idle_cycles_i == '0) begin
                            state   <= ST_OFF;
                            cg_en_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end else begin
                            state    <= ST_HOLD;
                            idle_cnt <= cg_if.idle_cycles_i - IDLE_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    ack_q <= '0;
                    // A new request wins over expiry; clock is still running so no wake delay.
                    if (any_req) begin
                        state <= ST_ON;
                    end else if (idle_cnt == '0) begin
                        state   <= ST_OFF;
                        cg_en_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt - IDLE_W'(1);
                    end
                end
                default: begin
                    state   <= ST_OFF;
                    ack_q   <= '0;
                    cg_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cg_if.ack_o   = ack_q;
    assign cg_if.cg_en_o = cg_en_q;
    assign cg_if.busy_o  = busy_q;

    // Scan enable opens the gate without disturbing the FSM.
    ehl_cg #(
        .TECHNOLOGY (TECHNOLOGY)
    ) u_cg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (cg_en_q | cg_if.test_en_i),
        .gclk    (cg_if.gclk_o)
    );

`ifdef EHL_CG_CTRL_STATS_EN
    logic [STATS_W-1:0] wake_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wake_cnt_q <= '0;
        else if (state == ST_OFF && any_req && wake_cnt_q != 16'hFFFF)
            wake_cnt_q <= wake_cnt_q + 16'd1;
    end

    assign wake_cnt_o = wake_cnt_q;
`endif

endmodule

// File: tb/tb_ehl_cg_ctrl.sv
// Bench for ehl_cg_ctrl: latch-based and flop-based gate instances share stimulus and a reference model.
module tb_ehl_cg_ctrl;
    localparam int REQ_NUM     = 4;
    localparam int IDLE_W      = 8;
    localparam int WAKE_CYCLES = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    ehl_cg_ctrl_if #(.REQ_NUM(REQ_NUM), .IDLE_W(IDLE_W)) if0 ();
    ehl_cg_ctrl_if #(.REQ_NUM(REQ_NUM), .IDLE_W(IDLE_W)) if1 ();

    assign if1.req_i         = if0.req_i;
    assign if1.idle_cycles_i = if0.idle_cycles_i;
    assign if1.test_en_i     = if0.test_en_i;

`ifdef EHL_CG_CTRL_STATS_EN
    logic [15:0] wake_cnt0;
    logic [15:0] wake_cnt1;
`endif

    ehl_cg_ctrl #(
        .TECHNOLOGY (0), .REQ_NUM (REQ_NUM), .IDLE_W (IDLE_W), .WAKE_CYCLES (WAKE_CYCLES)
    ) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .cg_if   (if0)
`ifdef EHL_CG_CTRL_STATS_EN
        , .wake_cnt_o (wake_cnt0)
`endif
    );

    ehl_cg_ctrl #(
        .TECHNOLOGY (1), .REQ_NUM (REQ_NUM), .IDLE_W (IDLE_W), .WAKE_CYCLES (WAKE_CYCLES)
    ) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .cg_if   (if1)
`ifdef EHL_CG_CTRL_STATS_EN
        , .wake_cnt_o (wake_cnt1)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [REQ_NUM-1:0] ack;
        logic               cg_en;
        logic               busy;
        logic               gclk_hi;
    } exp_t;

    exp_t q[$];

    // Reference model: the branch is either closed, waking (cycles left), granting, or idling (cycles left).
    bit                 m_open;
    bit                 m_on;
    int                 m_wake_left;
    int                 m_hold_left;
    int                 m_wakes;
    logic [REQ_NUM-1:0] m_ack;

    initial begin
        exp_t               e;
        logic [REQ_NUM-1:0] r;
        int                 idle;
        m_open = 0; m_on = 0; m_wake_left = 0; m_hold_left = 0; m_wakes = 0; m_ack = '0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_open = 0; m_on = 0; m_wake_left = 0; m_hold_left = 0; m_wakes = 0; m_ack = '0;
                q.delete();
            end else begin
                r         = if0.req_i;
                idle      = int'(if0.idle_cycles_i);
                e.gclk_hi = m_open | if0.test_en_i;
                if (!m_open) begin
                    m_ack = '0;
                    if (r != 0) begin
                        m_open      = 1;
                        m_wake_left = WAKE_CYCLES;
                        m_wakes++;
                    end
                end else if (m_wake_left > 0) begin
                    m_wake_left--;
                    if (m_wake_left == 0) begin
                        m_on  = 1;
                        m_ack = r;
                    end
                end else if (m_on) begin
                    m_ack = r;
                    if (r == 0) begin
                        m_on = 0;
                        if (idle == 0) m_open = 0;
                        else           m_hold_left = idle;
                    end
                end else begin
                    m_ack = '0;
                    if (r != 0) m_on = 1;
                    else begin
                        m_hold_left--;
                        if (m_hold_left == 0) m_open = 0;
                    end
                end
                e.ack   = m_ack;
                e.cg_en = m_open;
                e.busy  = m_open;
                q.push_back(e);
            end
        end
    end

    // Monitor: gclk checked in the high phase, registered outputs in the low phase.
    initial begin
        exp_t cur;
        bit   have;
        forever begin
            @(posedge clk);
            #1;
            have = 0;
            if (reset_n && q.size() > 0) begin
                cur  = q.pop_front();
                have = 1;
                chk("gclk_hi0", 32'(if0.gclk_o), 32'(cur.gclk_hi));
                chk("gclk_hi1", 32'(if1.gclk_o), 32'(cur.gclk_hi));
            end
            @(negedge clk);
            if (have && reset_n) begin
                chk("ack0",     32'(if0.ack_o),   32'(cur.ack));
                chk("ack1",     32'(if1.ack_o),   32'(cur.ack));
                chk("cg_en0",   32'(if0.cg_en_o), 32'(cur.cg_en));
                chk("cg_en1",   32'(if1.cg_en_o), 32'(cur.cg_en));
                chk("busy0",    32'(if0.busy_o),  32'(cur.busy));
                chk("busy1",    32'(if1.busy_o),  32'(cur.busy));
                chk("gclk_lo0", 32'(if0.gclk_o),  32'd0);
                chk("gclk_lo1", 32'(if1.gclk_o),  32'd0);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack0"},   32'(if0.ack_o),   32'd0);
        chk({tag, "_ack1"},   32'(if1.ack_o),   32'd0);
        chk({tag, "_cg_en0"}, 32'(if0.cg_en_o), 32'd0);
        chk({tag, "_cg_en1"}, 32'(if1.cg_en_o), 32'd0);
        chk({tag, "_busy0"},  32'(if0.busy_o),  32'd0);
        chk({tag, "_busy1"},  32'(if1.busy_o),  32'd0);
        chk({tag, "_gclk0"},  32'(if0.gclk_o),  32'd0);
        chk({tag, "_gclk1"},  32'(if1.gclk_o),  32'd0);
`ifdef EHL_CG_CTRL_STATS_EN
        chk({tag, "_wcnt0"},  32'(wake_cnt0),   32'd0);
        chk({tag, "_wcnt1"},  32'(wake_cnt1),   32'd0);
`endif
    endtask

    initial begin
        int idle_pick[5];
        idle_pick = '{0, 1, 2, 3, 5};
        if0.req_i         = '0;
        if0.idle_cycles_i = 8'd3;
        if0.test_en_i     = 1'b0;

        #1;
        chk_all_zero("reset");
        cyc(3);
        reset_n = 1'b1;

        cyc(10);                                   // idle, gate stays closed
        if0.req_i = 4'b0001; cyc(11);              // wake, grant, hold grant
        if0.req_i = 4'b0000; cyc(6);               // 3-cycle hold then off
        if0.req_i = 4'b0001; cyc(5);
        if0.req_i = 4'b0000; cyc(2);               // into HOLD, one idle cycle
        if0.req_i = 4'b0100; cyc(3);               // re-grant without wake delay
        if0.req_i = 4'b0000; cyc(6);

        if0.idle_cycles_i = 8'd0;
        if0.req_i = 4'b0001; cyc(1);               // dropped during WAKE, no hold-off
        if0.req_i = 4'b0000; cyc(6);
        if0.idle_cycles_i = 8'd3;
        if0.req_i = 4'b0010; cyc(1);               // dropped during WAKE, then HOLD
        if0.req_i = 4'b0000; cyc(8);

        if0.test_en_i = 1'b1; cyc(3);              // scan forces clock, FSM stays OFF
        if0.test_en_i = 1'b0; cyc(2);

        if0.req_i = 4'b1010; cyc(5);               // ON, then async reset
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(posedge clk);
        #2;
        if0.req_i = 4'b0000;
        reset_n   = 1'b1;
        cyc(2);

        if0.idle_cycles_i = 8'd0;
        repeat (3) begin
            if0.req_i = 4'b0001; cyc(1);
            if0.req_i = 4'b0000; cyc(6);
        end
`ifdef EHL_CG_CTRL_STATS_EN
        chk("wake3_cnt0", 32'(wake_cnt0), 32'd3);
        chk("wake3_cnt1", 32'(wake_cnt1), 32'd3);
`endif
        if0.idle_cycles_i = 8'd3;

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0)
                if0.req_i = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 19) == 0)
                if0.idle_cycles_i = 8'(idle_pick[$urandom_range(0, 4)]);
            if ($urandom_range(0, 49) == 0)
                if0.test_en_i = ~if0.test_en_i;
            cyc(1);
        end
        if0.req_i     = 4'b0000;
        if0.test_en_i = 1'b0;
        cyc(12);
`ifdef EHL_CG_CTRL_STATS_EN
        chk("wake_rand_cnt0", 32'(wake_cnt0), 32'(m_wakes));
        chk("wake_rand_cnt1", 32'(wake_cnt1), 32'(m_wakes));
`endif
        chk("idle_off_busy0", 32'(if0.busy_o), 32'd0);

        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 chk_all_zero("final_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
